memory_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the execute stage and consumes its EX/MEM values: ALU result, branch target, zero flag, destination register, store data, and M/WB controls. Drives a variable-latency word-wide data-memory handshake, stalls the pipeline while an access is outstanding, resolves the branch decision, and owns the MEM/WB pipeline register feeding write-back.

---
 rtl/memory_stage.sv | 138 +++++++++++++
 tb/tb_memory_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MEM stage: data-memory handshake, branch resolution and the MEM/WB register.
// One access in flight at a time; the pipeline stalls until it completes or times out.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ex_mem,
    input  logic [31:0] alu_result_ex_mem,
    input  logic [31:0] branch_address_ex_mem,
    input  logic        zero_ex_mem,
    input  logic [31:0] store_data_ex_mem,
    input  logic [4:0]  write_register_ex_mem,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic        ctrl_branch_ex_mem,
    input  logic        ctrl_memToReg_ex_mem,
    input  logic        ctrl_regWrite_ex_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        valid_mem_wb,
    output logic        ctrl_regWrite_mem_wb,
    output logic        ctrl_memToReg_mem_wb,
    output logic [31:0] read_data_mem_wb,
    output logic [31:0] alu_result_mem_wb,
    output logic [4:0]  write_register_mem_wb,
    output logic        mem_fault
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;

    logic        mem_op;
    logic        misaligned;
    logic        in_access;
    logic        at_limit;
    logic        wb_load;
    logic [31:0] wb_rdata;
    logic        fault;

    assign mem_op     = valid_ex_mem & (ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem);
    assign misaligned = mem_op & (alu_result_ex_mem[1:0] != 2'b00);
    assign in_access  = (state_q == ACCESS);
    assign at_limit   = (cnt_q == LAST_CNT);

    assign dmem_req   = in_access;
    assign dmem_we    = in_access & ctrl_memWrite_ex_mem;
    assign dmem_addr  = alu_result_ex_mem;
    assign dmem_wdata = store_data_ex_mem;

    assign pc_src        = valid_ex_mem & ctrl_branch_ex_mem & zero_ex_mem;
    assign branch_target = branch_address_ex_mem;

    // A ready on the last permitted cycle still completes the access.
    assign stall = in_access ? (~dmem_ready & ~at_limit)
                             : (mem_op & ~misaligned);

    always_comb begin
        wb_load  = 1'b0;
        wb_rdata = '0;
        fault    = 1'b0;
        if (in_access) begin
            if (dmem_ready) begin
                wb_load  = 1'b1;
                wb_rdata = ctrl_memWrite_ex_mem ? 32'h0 : dmem_rdata;
            end else if (at_limit) begin
                fault = 1'b1;
            end
        end else if (misaligned) begin
            fault = 1'b1;
        end else if (!mem_op) begin
            wb_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            mem_fault             <= 1'b0;
            valid_mem_wb          <= 1'b0;
            ctrl_regWrite_mem_wb  <= 1'b0;
            ctrl_memToReg_mem_wb  <= 1'b0;
            read_data_mem_wb      <= '0;
            alu_result_mem_wb     <= '0;
            write_register_mem_wb <= '0;
        end else begin
            mem_fault <= fault;
            unique case (state_q)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (dmem_ready || at_limit) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Anything not completing this cycle leaves a bubble behind.
            if (wb_load) begin
                valid_mem_wb          <= valid_ex_mem;
                ctrl_regWrite_mem_wb  <= ctrl_regWrite_ex_mem;
                ctrl_memToReg_mem_wb  <= ctrl_memToReg_ex_mem;
                read_data_mem_wb      <= wb_rdata;
                alu_result_mem_wb     <= alu_result_ex_mem;
                write_register_mem_wb <= write_register_ex_mem;
            end else begin
                valid_mem_wb          <= 1'b0;
                ctrl_regWrite_mem_wb  <= 1'b0;
                ctrl_memToReg_mem_wb  <= 1'b0;
                read_data_mem_wb      <= '0;
                alu_result_mem_wb     <= '0;
                write_register_mem_wb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a short timeout.
// Each task drives one scenario and checks against hand-computed values.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex_mem;
    logic [31:0] alu_result_ex_mem;
    logic [31:0] branch_address_ex_mem;
    logic        zero_ex_mem;
    logic [31:0] store_data_ex_mem;
    logic [4:0]  write_register_ex_mem;
    logic        ctrl_memRead_ex_mem;
    logic        ctrl_memWrite_ex_mem;
    logic        ctrl_branch_ex_mem;
    logic        ctrl_memToReg_ex_mem;
    logic        ctrl_regWrite_ex_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        valid_mem_wb;
    logic        ctrl_regWrite_mem_wb;
    logic        ctrl_memToReg_mem_wb;
    logic [31:0] read_data_mem_wb;
    logic [31:0] alu_result_mem_wb;
    logic [4:0]  write_register_mem_wb;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .valid_ex_mem          (valid_ex_mem),
        .alu_result_ex_mem     (alu_result_ex_mem),
        .branch_address_ex_mem (branch_address_ex_mem),
        .zero_ex_mem           (zero_ex_mem),
        .store_data_ex_mem     (store_data_ex_mem),
        .write_register_ex_mem (write_register_ex_mem),
        .ctrl_memRead_ex_mem   (ctrl_memRead_ex_mem),
        .ctrl_memWrite_ex_mem  (ctrl_memWrite_ex_mem),
        .ctrl_branch_ex_mem    (ctrl_branch_ex_mem),
        .ctrl_memToReg_ex_mem  (ctrl_memToReg_ex_mem),
        .ctrl_regWrite_ex_mem  (ctrl_regWrite_ex_mem),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_ready            (dmem_ready),
        .dmem_rdata            (dmem_rdata),
        .stall                 (stall),
        .pc_src                (pc_src),
        .branch_target         (branch_target),
        .valid_mem_wb          (valid_mem_wb),
        .ctrl_regWrite_mem_wb  (ctrl_regWrite_mem_wb),
        .ctrl_memToReg_mem_wb  (ctrl_memToReg_mem_wb),
        .read_data_mem_wb      (read_data_mem_wb),
        .alu_result_mem_wb     (alu_result_mem_wb),
        .write_register_mem_wb (write_register_mem_wb),
        .mem_fault             (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic clear_ex();
        valid_ex_mem          = 1'b0;
        alu_result_ex_mem     = '0;
        branch_address_ex_mem = '0;
        zero_ex_mem           = 1'b0;
        store_data_ex_mem     = '0;
        write_register_ex_mem = '0;
        ctrl_memRead_ex_mem   = 1'b0;
        ctrl_memWrite_ex_mem  = 1'b0;
        ctrl_branch_ex_mem    = 1'b0;
        ctrl_memToReg_ex_mem  = 1'b0;
        ctrl_regWrite_ex_mem  = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
        clear_ex();
        valid_ex_mem          = 1'b1;
        alu_result_ex_mem     = addr;
        write_register_ex_mem = rd;
        ctrl_memRead_ex_mem   = 1'b1;
        ctrl_memToReg_ex_mem  = 1'b1;
        ctrl_regWrite_ex_mem  = 1'b1;
    endtask

    // Stimulus driver only: called at posedge+1 with the instruction already
    // on the EX/MEM inputs; answers ready after 'waits' request cycles.
    task automatic run_access(input int waits,
                              output int stall_n, output int req_n,
                              output int fault_n, output int unstable,
                              output bit done,
                              output logic [31:0] addr_s,
                              output logic [31:0] wdata_s,
                              output logic we_s);
        stall_n = 0; req_n = 0; fault_n = 0; unstable = 0; done = 1'b0;
        addr_s = '0; wdata_s = '0; we_s = 1'b0;
        for (int c = 0; c < 40 && !done && fault_n == 0; c++) begin
            dmem_ready = dmem_req && (req_n == waits);
            @(negedge clk);
            if (stall) stall_n++;
            if (dmem_req) begin
                if (req_n == 0) begin
                    addr_s = dmem_addr; wdata_s = dmem_wdata; we_s = dmem_we;
                end else if ({dmem_addr, dmem_wdata, dmem_we} !==
                             {addr_s, wdata_s, we_s}) begin
                    unstable++;
                end
                req_n++;
            end
            if (dmem_ready) done = 1'b1;
            @(posedge clk); #1;
            if (mem_fault) fault_n++;
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        clear_ex();
        #12;
        checks++;
        if ({valid_mem_wb, ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb,
             read_data_mem_wb, alu_result_mem_wb, write_register_mem_wb,
             dmem_req, mem_fault} !== '0)
            begin errors++; $display("FAIL reset_outputs: got nonzero req=%b fault=%b valid=%b", dmem_req, mem_fault, valid_mem_wb); end
        checks++;
        if ({stall, pc_src} !== 2'b00)
            begin errors++; $display("FAIL reset_stall: got %b expected 00", {stall, pc_src}); end
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        @(posedge clk); #1;
        clear_ex();
        valid_ex_mem = 1'b1; alu_result_ex_mem = 32'h10;
        write_register_ex_mem = 5'd5; ctrl_regWrite_ex_mem = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall, dmem_req} !== 2'b00)
            begin errors++; $display("FAIL pass_stall: got %b expected 00", {stall, dmem_req}); end
        @(posedge clk); #1;
        checks++;
        if ({valid_mem_wb, ctrl_regWrite_mem_wb, alu_result_mem_wb,
             write_register_mem_wb, read_data_mem_wb} !==
            {1'b1, 1'b1, 32'h10, 5'd5, 32'h0})
            begin errors++; $display("FAIL pass_wb: got v=%b rw=%b alu=%h wr=%0d rd=%h expected 1 1 10 5 0", valid_mem_wb, ctrl_regWrite_mem_wb, alu_result_mem_wb, write_register_mem_wb, read_data_mem_wb); end
        clear_ex();
    endtask

    task automatic test_zero_wait_load();
        int sn, rn, fn, un; bit dn; logic [31:0] a, w; logic we;
        @(posedge clk); #1;
        drive_load(32'h100, 5'd8);
        dmem_rdata = 32'hDEAD_BEEF;
        run_access(0, sn, rn, fn, un, dn, a, w, we);
        checks++;
        if (!dn || sn != 1 || rn != 1 || fn != 0)
            begin errors++; $display("FAIL zw_timing: got done=%b stall=%0d req=%0d fault=%0d expected 1 1 1 0", dn, sn, rn, fn); end
        checks++;
        if ({a, we} !== {32'h100, 1'b0})
            begin errors++; $display("FAIL zw_addr: got %h we=%b expected 100 we=0", a, we); end
        checks++;
        if ({read_data_mem_wb, ctrl_memToReg_mem_wb, valid_mem_wb, write_register_mem_wb} !==
            {32'hDEAD_BEEF, 1'b1, 1'b1, 5'd8})
            begin errors++; $display("FAIL zw_wb: got %h m2r=%b v=%b wr=%0d expected deadbeef 1 1 8", read_data_mem_wb, ctrl_memToReg_mem_wb, valid_mem_wb, write_register_mem_wb); end
        clear_ex();
    endtask

    // Ready lands on counter == TIMEOUT_CYCLES-1, so it must complete, not fault.
    task automatic test_wait_store();
        int sn, rn, fn, un; bit dn; logic [31:0] a, w; logic we;
        @(posedge clk); #1;
        clear_ex();
        valid_ex_mem = 1'b1; alu_result_ex_mem = 32'h200;
        store_data_ex_mem = 32'h1234_5678; ctrl_memWrite_ex_mem = 1'b1;
        run_access(3, sn, rn, fn, un, dn, a, w, we);
        checks++;
        if (!dn || sn != 4 || rn != 4 || fn != 0 || un != 0)
            begin errors++; $display("FAIL st_timing: got done=%b stall=%0d req=%0d fault=%0d unstable=%0d expected 1 4 4 0 0", dn, sn, rn, fn, un); end
        checks++;
        if ({a, w, we} !== {32'h200, 32'h1234_5678, 1'b1})
            begin errors++; $display("FAIL st_bus: got %h %h we=%b expected 200 12345678 1", a, w, we); end
        checks++;
        if ({ctrl_regWrite_mem_wb, read_data_mem_wb, valid_mem_wb} !== {1'b0, 32'h0, 1'b1})
            begin errors++; $display("FAIL st_wb: got rw=%b rd=%h v=%b expected 0 0 1", ctrl_regWrite_mem_wb, read_data_mem_wb, valid_mem_wb); end
        clear_ex();
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        drive_load(32'h102, 5'd9);
        @(negedge clk);
        checks++;
        if ({stall, dmem_req} !== 2'b00)
            begin errors++; $display("FAIL mis_req: got %b expected 00", {stall, dmem_req}); end
        @(posedge clk); #1;
        checks++;
        if ({mem_fault, valid_mem_wb, ctrl_regWrite_mem_wb} !== 3'b100)
            begin errors++; $display("FAIL mis_fault: got %b expected 100", {mem_fault, valid_mem_wb, ctrl_regWrite_mem_wb}); end
        clear_ex();
        @(posedge clk); #1;
        checks++;
        if ({mem_fault, dmem_req} !== 2'b00)
            begin errors++; $display("FAIL mis_pulse: got %b expected 00", {mem_fault, dmem_req}); end
    endtask

    task automatic test_timeout();
        int sn, rn, fn, un; bit dn; logic [31:0] a, w; logic we;
        @(posedge clk); #1;
        drive_load(32'h300, 5'd10);
        run_access(100, sn, rn, fn, un, dn, a, w, we);
        checks++;
        if (dn || rn != 4 || sn != 4 || fn != 1)
            begin errors++; $display("FAIL to_timing: got done=%b req=%0d stall=%0d fault=%0d expected 0 4 4 1", dn, rn, sn, fn); end
        checks++;
        if ({valid_mem_wb, ctrl_regWrite_mem_wb, dmem_req} !== 3'b000)
            begin errors++; $display("FAIL to_bubble: got %b expected 000", {valid_mem_wb, ctrl_regWrite_mem_wb, dmem_req}); end
        clear_ex();
        @(posedge clk); #1;
        checks++;
        if ({mem_fault, dmem_req} !== 2'b00)
            begin errors++; $display("FAIL to_idle: got %b expected 00", {mem_fault, dmem_req}); end
    endtask

    task automatic test_idle_ready();
        @(posedge clk); #1;
        clear_ex();
        valid_ex_mem = 1'b1; alu_result_ex_mem = 32'h44;
        write_register_ex_mem = 5'd3; ctrl_regWrite_ex_mem = 1'b1;
        dmem_ready = 1'b1; dmem_rdata = 32'h0000_FFFF;
        @(negedge clk);
        checks++;
        if ({stall, dmem_req} !== 2'b00)
            begin errors++; $display("FAIL idle_rdy_req: got %b expected 00", {stall, dmem_req}); end
        @(posedge clk); #1;
        checks++;
        if ({read_data_mem_wb, alu_result_mem_wb} !== {32'h0, 32'h44})
            begin errors++; $display("FAIL idle_rdy_wb: got %h %h expected 0 44", read_data_mem_wb, alu_result_mem_wb); end
        dmem_ready = 1'b0;
        clear_ex();
    endtask

    task automatic test_back_to_back();
        int sn, rn, fn, un; bit dn; logic [31:0] a, w; logic we;
        @(posedge clk); #1;
        drive_load(32'h400, 5'd11);
        dmem_rdata = 32'hAAAA_0001;
        run_access(0, sn, rn, fn, un, dn, a, w, we);
        checks++;
        if (!dn || sn != 1 || read_data_mem_wb !== 32'hAAAA_0001)
            begin errors++; $display("FAIL b2b_first: got done=%b stall=%0d rd=%h expected 1 1 aaaa0001", dn, sn, read_data_mem_wb); end
        drive_load(32'h404, 5'd12);
        dmem_rdata = 32'hBBBB_0002;
        checks++;
        if (dmem_req !== 1'b0)
            begin errors++; $display("FAIL b2b_gap: got req=%b expected 0", dmem_req); end
        run_access(1, sn, rn, fn, un, dn, a, w, we);
        checks++;
        if (!dn || sn != 2 || rn != 2 || a !== 32'h404 ||
            {read_data_mem_wb, write_register_mem_wb} !== {32'hBBBB_0002, 5'd12})
            begin errors++; $display("FAIL b2b_second: got done=%b stall=%0d req=%0d addr=%h rd=%h wr=%0d expected 1 2 2 404 bbbb0002 12", dn, sn, rn, a, read_data_mem_wb, write_register_mem_wb); end
        clear_ex();
    endtask

    task automatic test_branch();
        @(posedge clk); #1;
        clear_ex();
        valid_ex_mem = 1'b1; ctrl_branch_ex_mem = 1'b1; zero_ex_mem = 1'b1;
        branch_address_ex_mem = 32'h0000_0ABC;
        #1;
        checks++;
        if ({pc_src, branch_target, stall} !== {1'b1, 32'h0000_0ABC, 1'b0})
            begin errors++; $display("FAIL br_taken: got %b %h stall=%b expected 1 abc 0", pc_src, branch_target, stall); end
        zero_ex_mem = 1'b0;
        #1;
        checks++;
        if (pc_src !== 1'b0)
            begin errors++; $display("FAIL br_not_taken: got %b expected 0", pc_src); end
        clear_ex();
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        drive_load(32'h500, 5'd13);
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1)
            begin errors++; $display("FAIL rst_pre: got req=%b expected 1", dmem_req); end
        #2;
        reset = 1'b0;
        clear_ex();
        #1;
        checks++;
        if ({dmem_req, mem_fault, valid_mem_wb, ctrl_regWrite_mem_wb,
             ctrl_memToReg_mem_wb, read_data_mem_wb, alu_result_mem_wb,
             write_register_mem_wb, stall} !== '0)
            begin errors++; $display("FAIL rst_mid: got req=%b fault=%b v=%b stall=%b expected all 0", dmem_req, mem_fault, valid_mem_wb, stall); end
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({dmem_req, stall} !== 2'b00)
            begin errors++; $display("FAIL rst_idle: got %b expected 00", {dmem_req, stall}); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_zero_wait_load();
        test_wait_store();
        test_misaligned();
        test_timeout();
        test_idle_ready();
        test_back_to_back();
        test_branch();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
